// File: rtl/dsm_decim_sinc2.sv
// Second-order CIC (sinc2) decimator: rebuilds a signed DW-bit word from a
// 1-bit DSM bitstream, one word per R = 2^LOG2_R accepted samples.
module dsm_decim_sinc2 #(
  parameter int DW     = 9,
  parameter int LOG2_R = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync_clr,
  input  logic          din,
  input  logic          din_valid,
  output logic [DW-1:0] dout,
  output logic          dout_valid
);

  localparam int W  = DW + 2*LOG2_R;
  localparam int SH = 2*LOG2_R;

  // Bit levels +2^(DW-2)-1 / -2^(DW-2); the negative level is the bitwise inverse.
  localparam logic signed [W-1:0] XP   = W'(2**(DW-2) - 1);
  localparam logic signed [W-1:0] XN   = ~XP;
  localparam logic signed [W-1:0] YMAX = XP;
  localparam logic signed [W-1:0] YMIN = XN;

  logic signed [W-1:0]  x, i1, i2, i2_d, c1_d, c1, c2, y_sh;
  logic signed [DW-1:0] y;
  logic [LOG2_R-1:0]    cnt;
  logic                 tick, warm;

  always_comb begin
    x    = din ? XP : XN;
    c1   = i2 - i2_d;
    c2   = c1 - c1_d;
    y_sh = c2 >>> SH;
    if (y_sh > YMAX)      y = YMAX[DW-1:0];
    else if (y_sh < YMIN) y = YMIN[DW-1:0];
    else                  y = y_sh[DW-1:0];
  end

  // All arithmetic wraps modulo 2^W on purpose; the comb differences cancel it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1 <= '0; i2 <= '0; i2_d <= '0; c1_d <= '0;
      cnt <= '0; tick <= 1'b0; warm <= 1'b0;
      dout <= '0; dout_valid <= 1'b0;
    end else if (sync_clr) begin
      i1 <= '0; i2 <= '0; i2_d <= '0; c1_d <= '0;
      cnt <= '0; tick <= 1'b0; warm <= 1'b0;
      dout <= '0; dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (din_valid) begin
        i1  <= i1 + x;
        i2  <= i2 + i1;
        cnt <= cnt + 1'b1;
      end
      tick <= din_valid && (cnt == '1);
      // Comb uses pre-edge i2, i.e. the value latched at the frame boundary.
      if (tick) begin
        i2_d <= i2;
        c1_d <= c1;
        warm <= 1'b1;
        if (warm) begin
          dout       <= y;
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsm_decim_sinc2.sv
// Directed/table-driven bench for dsm_decim_sinc2 with a direct-form
// triangular FIR reference and a behavioural first-order DSM source.
module tb_dsm_decim_sinc2;
  localparam int LOG2_R = 6;
  localparam int R      = 64;
  localparam int R2     = 1024;

  logic       clk = 1'b0, rst = 1'b0, sync_clr = 1'b0, din = 1'b0, din_valid = 1'b0;
  logic [8:0] dout, dout2;
  logic       dout_valid, dout_valid2;

  always #5 clk = ~clk;

  dsm_decim_sinc2 #(.DW(9), .LOG2_R(LOG2_R)) dut (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid));

  dsm_decim_sinc2 #(.DW(9), .LOG2_R(10)) dut2 (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .din(din), .din_valid(din_valid),
    .dout(dout2), .dout_valid(dout_valid2));

  typedef struct {
    int mode;   // 0: constant bit di[0], 1: DSM driven by di
    int duty;   // din_valid probability in percent
    int di;
    int nsamp;
    int lo;
    int hi;
  } vec_t;

  int  errors = 0, checks = 0;
  int  xs[$];
  int  acc, pend_y, exp_dout, dsm_s, strobes = 0, strobes2 = 0;
  bit  pend, exp_v, mon2 = 1'b0;

  function automatic int model_y();
    longint s = 0;
    for (int t = acc - 2*R; t <= acc - 2; t++) begin
      int d, h;
      d = acc - 1 - t;
      h = (d <= R) ? d : 2*R - d;
      s += longint'(h) * longint'(xs[t]);
    end
    s = s >>> (2*LOG2_R);
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return int'(s);
  endfunction

  function automatic bit dsm_bit(input int u);
    bit y;
    y = (dsm_s >= 0);
    dsm_s += u - (y ? 127 : -128);
    return y;
  endfunction

  task automatic model_clear();
    xs.delete();
    acc = 0; pend = 0; exp_v = 0; exp_dout = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit d, input bit v, input bit c);
    din = d; din_valid = v; sync_clr = c;
    if (!rst || c) model_clear();
    else begin
      exp_v = pend;
      if (pend) exp_dout = pend_y;
      pend = 0;
      if (v) begin
        xs.push_back(d ? 127 : -128);
        acc++;
        if (acc % R == 0 && acc >= 2*R) begin
          pend   = 1;
          pend_y = model_y();
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (dout_valid !== exp_v || int'($signed(dout)) != exp_dout) begin
      errors++;
      $display("FAIL step acc=%0d: valid=%b dout=%0d, expected valid=%b dout=%0d",
               acc, dout_valid, $signed(dout), exp_v, exp_dout);
    end
    if (dout_valid) strobes++;
    if (mon2 && dout_valid2) begin
      strobes2++;
      check("wrap_dout", int'($signed(dout2)), 127);
    end
    sync_clr = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int s0, n;
    bit v, d;
    vecs[0] = '{0, 100,    1,  6*R,  127,  127};
    vecs[1] = '{0, 100,    0,  6*R, -128, -128};
    vecs[2] = '{0,  30,    1,  4*R,  127,  127};
    vecs[3] = '{1,  50,   64, 12*R,   63,   65};
    vecs[4] = '{1, 100,    0,  8*R,   -1,    1};
    vecs[5] = '{1,  70, -100,  8*R, -102,  -98};
    model_clear();

    // Reset held: activity on din must not reach the outputs.
    for (int i = 0; i < 10; i++) step(i[0], 1'b1, 1'b0);
    #3 rst = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 500; i++) step(1'b1, 1'b0, 1'b0);
    check("idle_strobes", strobes - s0, 0);

    foreach (vecs[k]) begin
      step(1'b0, 1'b0, 1'b1);
      dsm_s = 0; n = 0; s0 = strobes;
      while (n < vecs[k].nsamp) begin
        v = ($urandom_range(99) < vecs[k].duty);
        if (!v)                 d = $urandom_range(1);
        else if (vecs[k].mode)  d = dsm_bit(vecs[k].di);
        else                    d = vecs[k].di[0];
        step(d, v, 1'b0);
        if (v) n++;
        if (dout_valid) begin
          checks++;
          if ($signed(dout) < vecs[k].lo || $signed(dout) > vecs[k].hi) begin
            errors++;
            $display("FAIL range row %0d: dout=%0d, expected %0d..%0d",
                     k, $signed(dout), vecs[k].lo, vecs[k].hi);
          end
        end
      end
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("strobe_count_row%0d", k), strobes - s0, vecs[k].nsamp / R - 1);
    end

    // sync_clr on the 100th sample edge, with din_valid high: sample dropped.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 99; i++) step(1'b1, 1'b1, 1'b0);
    s0 = strobes;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 127; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("clr_no_early_strobe", strobes - s0, 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("clr_first_strobe", strobes - s0, 1);
    check("clr_first_dout", int'($signed(dout)), 127);

    // Same restart via asynchronous reset asserted mid-cycle.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 99; i++) step(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    model_clear();
    #1;
    check("async_rst_valid", int'(dout_valid), 0);
    check("async_rst_dout", int'($signed(dout)), 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #3 rst = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 127; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("rst_no_early_strobe", strobes - s0, 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("rst_first_strobe", strobes - s0, 1);
    check("rst_first_dout", int'($signed(dout)), 127);

    // LOG2_R = 10, all ones for 20 frames: integrators wrap, output stays 127.
    step(1'b0, 1'b0, 1'b1);
    mon2 = 1'b1;
    for (int i = 0; i < 20*R2; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    mon2 = 1'b0;
    check("wrap_strobe_count", strobes2, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
